tbird_seq: RTL and testbench

- Parametrised tail-light sequencer that drives LAMPS lamps per side.
- Modes: left turn, right turn, hazard. Turn modes run a thermometer sweep outward; hazard flashes all lamps on both sides.
- An internal prescaler sets the step rate from the system clock.
- Sits between the switch/key inputs and the LEDR lamp banks. Successor to the fixed 3-lamp, turn-only light controller.

---
 rtl/tbird_seq.sv | 107 ++++++++++
 tb/tb_tbird_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tbird_seq.sv
// tbird_seq: parametrised tail-light sequencer (left/right sweep, hazard flash); optional brake input under TBIRD_BRAKE_EN
module tbird_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef TBIRD_BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic [1:0]       mode
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(LAMPS + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, HAZ = 2'b11} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] step_q, step_d, step_inc;
  logic [LAMPS-1:0] ll_q, ll_d, lr_q, lr_d, therm;
  logic tick, hz_req, l_req, r_req;
  assign tick     = cnt_q == CW'(DIV - 1);
  assign hz_req   = hazard | (left & right);
  assign l_req    = left & ~right & ~hazard;
  assign r_req    = right & ~left & ~hazard;
  assign step_inc = step_q + 1'b1;
  // thermometer of the step being entered: lamps below step_inc are lit
  for (genvar i = 0; i < LAMPS; i++) begin : g_therm
    assign therm[i] = i < int'(step_inc);
  end
  // free-running prescaler, wraps on tick
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 1'b1;
  // next mode, step and lamp image; everything holds between ticks
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ll_d    = ll_q;
    lr_d    = lr_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hz_req) begin
            state_d = HAZ;
            ll_d    = '1;
            lr_d    = '1;
          end else if (l_req || r_req) begin
            state_d = l_req ? LEFT : RIGHT;
            step_d  = SW'(1);
            ll_d    = l_req ? therm : '0;
            lr_d    = l_req ? '0 : therm;
          end
        end
        LEFT, RIGHT: begin
          if (hz_req) begin
            state_d = HAZ;
            step_d  = '0;
            ll_d    = '1;
            lr_d    = '1;
          end else if (step_q < SW'(LAMPS)) begin
            step_d = step_inc;
            ll_d   = state_q == LEFT ? therm : '0;
            lr_d   = state_q == RIGHT ? therm : '0;
          end else begin
            state_d = IDLE;
            step_d  = '0;
            ll_d    = '0;
            lr_d    = '0;
          end
        end
        HAZ: begin
          state_d = hz_req ? HAZ : IDLE;
          step_d  = '0;
          ll_d    = hz_req ? ~ll_q : '0;
          lr_d    = hz_req ? ~lr_q : '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state, step and lamp registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      ll_q    <= '0;
      lr_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ll_q    <= ll_d;
      lr_q    <= lr_d;
    end
`ifdef TBIRD_BRAKE_EN
  assign lamp_l = ll_q | {LAMPS{brake & (state_q == IDLE || state_q == RIGHT)}};
  assign lamp_r = lr_q | {LAMPS{brake & (state_q == IDLE || state_q == LEFT)}};
`else
  assign lamp_l = ll_q;
  assign lamp_r = lr_q;
`endif
  assign mode = state_q;
endmodule

// File: tb/tb_tbird_seq.sv
// tb_tbird_seq: scoreboard bench for tbird_seq with DIV=1 and DIV=4 instances
module tb_tbird_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lf[2], rt[2], hz[2];
  logic [2:0] ll0, lr0, ll1, lr1;
  logic [1:0] md0, md1;
  int n_chk = 0, n_fail = 0;
  int cnt[2], st[2], stp[2];
  logic [2:0] ml[2], mr[2];
  logic [7:0] q0[$], q1[$];
  logic [2:0] seq[10] = '{3'd1, 3'd3, 3'd7, 3'd0, 3'd1, 3'd3, 3'd7, 3'd0, 3'd1, 3'd3};

  always #5 clk = ~clk;

  tbird_seq #(.LAMPS(3), .DIV(1)) u0 (
    .clk(clk), .reset(reset), .left(lf[0]), .right(rt[0]), .hazard(hz[0]),
    .lamp_l(ll0), .lamp_r(lr0), .mode(md0)
  );
  tbird_seq #(.LAMPS(3), .DIV(4)) u1 (
    .clk(clk), .reset(reset), .left(lf[1]), .right(rt[1]), .hazard(hz[1]),
    .lamp_l(ll1), .lamp_r(lr1), .mode(md1)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; st[k] = 0; stp[k] = 0; ml[k] = 3'd0; mr[k] = 3'd0;
    end
  endtask

  task automatic model(int k, int div);
    logic h, l, r;
    if (cnt[k] != div - 1) begin
      cnt[k]++;
      return;
    end
    cnt[k] = 0;
    h = hz[k] | (lf[k] & rt[k]);
    l = lf[k] & ~rt[k] & ~hz[k];
    r = rt[k] & ~lf[k] & ~hz[k];
    if (st[k] == 3) begin
      if (h) begin ml[k] = ~ml[k]; mr[k] = ~mr[k]; end
      else begin st[k] = 0; ml[k] = 3'd0; mr[k] = 3'd0; end
    end else if (h) begin
      st[k] = 3; stp[k] = 0; ml[k] = 3'd7; mr[k] = 3'd7;
    end else begin
      if (st[k] == 0) begin
        if (l | r) begin st[k] = l ? 1 : 2; stp[k] = 1; end
      end else if (stp[k] == 3) begin
        st[k] = 0; stp[k] = 0;
      end else stp[k]++;
      ml[k] = st[k] == 1 ? 3'((1 << stp[k]) - 1) : 3'd0;
      mr[k] = st[k] == 2 ? 3'((1 << stp[k]) - 1) : 3'd0;
    end
  endtask

  function automatic logic [7:0] expv(int k);
    return {st[k][1:0], ml[k], mr[k]};
  endfunction

  task automatic cyc();
    model(0, 1);
    model(1, 4);
    q0.push_back(expv(0));
    q1.push_back(expv(1));
    @(posedge clk);
    #1;
    chk("sb_div1", {md0, ll0, lr0}, q0.pop_front());
    chk("sb_div4", {md1, ll1, lr1}, q1.pop_front());
  endtask

  task automatic drive(int k, logic l, logic r, logic h);
    lf[k] = l; rt[k] = r; hz[k] = h;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 1'b0);
    mreset();
    #12;
    chk("rst_div1", {md0, ll0, lr0}, 8'h00);
    chk("rst_div4", {md1, ll1, lr1}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(0, i < 10, 1'b0, 1'b0);
      drive(1, 1'b0, i < 4, 1'b0);
      cyc();
      if (i < 10) chk("left_seq", ll0, seq[i]);
      if (i < 10) chk("left_r_off", lr0, 3'd0);
      if (i == 2) chk("div4_pre", lr1, 3'd0);
      if (i == 3) chk("div4_s1", lr1, 3'd1);
      if (i == 11) chk("div4_s3", lr1, 3'd7);
      if (i == 15) chk("div4_end", {md1, lr1}, 5'b00_000);
    end
    drive(0, 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("pre_step2", ll0, 3'd3);
    drive(0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("hz_preempt", {md0, ll0, lr0}, 8'hFF);
    cyc();
    chk("hz_toggle", {md0, ll0, lr0}, 8'b11_000_000);
    repeat (3) cyc();
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("hz_exit", {md0, ll0, lr0}, 8'h00);
    for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("lr_is_hz", {md0, ll0, lr0}, 8'hFF);
    repeat (8) cyc();
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc();
    for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b0, 1'b0);
    repeat (6) cyc();
    #3 reset = 1'b1;
    #1;
    chk("arst_div1", {md0, ll0, lr0}, 8'h00);
    chk("arst_div4", {md1, ll1, lr1}, 8'h00);
    mreset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      if (j == 2) chk("rel_wait", ll1, 3'd0);
      if (j == 3) chk("rel_first", ll1, 3'd1);
    end
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 2; k++)
        drive(k, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
